// File: rtl/comparador_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the
// one-hot {menor, igual, mayor} result record.
package comparador_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef struct packed {
        logic menor;
        logic igual;
        logic mayor;
    } result_t;

endpackage

// File: rtl/comparador_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice, built as an
// MSB-first equal-prefix / less-than cascade (no subtractor).
module comparador_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             eq
);

    // eq carries "all higher bits equal"; the first differing bit decides lt.
    always_comb begin
        lt = 1'b0;
        eq = 1'b1;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            lt = lt | (eq & ~a[i] & b[i]);
            eq = eq & ~(a[i] ^ b[i]);
        end
    end

endmodule

// File: rtl/comparador_serial.sv
// Serial A-vs-B magnitude comparator: examines CHUNK bits per clock, MSB first,
// terminating on the first differing chunk. Signed mode uses offset binary.
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             menor,
    output logic             igual,
    output logic             mayor
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [K_W-1:0]   K_LAST   = K_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t           state, state_n;
    logic [K_W-1:0]   k;
    logic [WIDTH-1:0] a_q, b_q;
    result_t          res;
    logic             load;
    logic             chunk_lt, chunk_eq;

    // Operands shift left after every equal chunk, so chunk k is always on top.
    comparador_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_q[WIDTH-1 -: CHUNK]),
        .b  (b_q[WIDTH-1 -: CHUNK]),
        .lt (chunk_lt),
        .eq (chunk_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = COMPARE;
                end
            end
            COMPARE: begin
                busy = 1'b1;
                if (!chunk_eq || k == K_LAST) state_n = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Inverting both MSBs in signed mode lets the unsigned cascade order two's-complement values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            k   <= '0;
            res <= '0;
        end else if (load) begin
            a_q <= A ^ (MSB_MASK & {WIDTH{signed_mode}});
            b_q <= B ^ (MSB_MASK & {WIDTH{signed_mode}});
            k   <= '0;
        end else if (state == COMPARE) begin
            if (!chunk_eq) begin
                res <= '{menor: chunk_lt, igual: 1'b0, mayor: ~chunk_lt};
            end else if (k == K_LAST) begin
                res <= '{menor: 1'b0, igual: 1'b1, mayor: 1'b0};
            end else begin
                k   <= k + K_W'(1);
                a_q <= a_q << CHUNK;
                b_q <= b_q << CHUNK;
            end
        end
    end

    assign menor = res.menor;
    assign igual = res.igual;
    assign mayor = res.mayor;

endmodule

// File: tb/tb_comparador_serial.sv
// Scoreboard bench for comparador_serial (WIDTH=16, CHUNK=4): directed cases,
// ignored starts, mid-compare reset and a random back-to-back sweep.
module tb_comparador_serial;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;

    typedef struct {
        logic [2:0] res;
        int         acc;
        int         d;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             signed_mode = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             busy, done, menor, igual, mayor;

    exp_t       sb[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [2:0] last_res = '0;
    bit         have_res = 1'b0;

    comparador_serial #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .menor       (menor),
        .igual       (igual),
        .mayor       (mayor)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic sm, input int acc);
        exp_t             e;
        logic signed [WIDTH:0] sa, sbv;
        logic [WIDTH-1:0] x;
        sa  = {sm & a[WIDTH-1], a};
        sbv = {sm & b[WIDTH-1], b};
        if (sa < sbv)       e.res = 3'b100;
        else if (sa == sbv) e.res = 3'b010;
        else                e.res = 3'b001;
        x   = a ^ b;
        e.d = WIDTH / CHUNK;
        for (int j = WIDTH / CHUNK - 1; j >= 0; j--)
            if (x[WIDTH-1-j*CHUNK -: CHUNK] != '0) e.d = j + 1;
        e.acc = acc;
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm);
        int guard = 0;
        while (busy === 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) chk("busy_timeout", 1, 0);
        A           = a;
        B           = b;
        signed_mode = sm;
        start       = 1'b1;
        sb.push_back(model(a, b, sm, cyc + 1));
        @(negedge clk);
        start       = 1'b0;
        A           = ~a;
        B           = 16'($urandom);
        signed_mode = ~sm;
    endtask

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_res = 1'b0;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("result", {menor, igual, mayor}, mon_e.res);
                chk("latency", cyc - mon_e.acc, mon_e.d);
                chk("busy_in_done", busy, 1);
                last_res = mon_e.res;
                have_res = 1'b1;
            end
        end else if (have_res) begin
            chk("hold", {menor, igual, mayor}, last_res);
        end
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int guard;

        #2 rst_n = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", {menor, igual, mayor}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        issue(16'h1234, 16'h1235, 1'b0);
        chk("busy_after_accept", busy, 1);
        issue(16'h8000, 16'h0001, 1'b0);
        issue(16'h8000, 16'h0001, 1'b1);
        issue(16'hBEEF, 16'hBEEF, 1'b0);
        issue(16'hBEEF, 16'hBEEF, 1'b1);
        issue(16'hFFFF, 16'h0000, 1'b1);

        issue(16'h1234, 16'h1235, 1'b0);
        for (int i = 0; i < 5; i++) begin
            A           = 16'($urandom);
            B           = 16'($urandom);
            signed_mode = 1'($urandom);
            start       = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;

        issue(16'h0001, 16'h0002, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", {menor, igual, mayor}, 3'b000);
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            chk("no_done_after_rst", done, 0);
            @(negedge clk);
        end
        issue(16'h0003, 16'h0002, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'($urandom);
                1:       rb = ra;
                default: rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, 3)));
            endcase
            issue(ra, rb, 1'($urandom));
        end

        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
